// File: rtl/rgb_led_pkg.sv
// rgb_led_pkg: shared types and constants for the RGB LED frame scheduler.
package rgb_led_pkg;
    localparam int LED_W = 12;
    typedef enum logic [1:0] {IDLE, SHOW_RND, SHOW_OVR, BLANK} state_t;
    localparam int LED1_R = 11, LED1_G = 10, LED1_B = 9;
    localparam int LED2_R = 8, LED2_G = 7, LED2_B = 6;
    localparam int LED3_R = 5, LED3_G = 4, LED3_B = 3;
    localparam int LED4_R = 2, LED4_G = 1, LED4_B = 0;
endpackage

// File: rtl/led_frame_timer.sv
// led_frame_timer: frame prescaler plus per-state frame counter.
// done fires on the frame tick that completes the current state's frame budget.
module led_frame_timer #(
    parameter int CLK_DIV      = 50000000,
    parameter int HOLD_FRAMES  = 4,
    parameter int BLANK_FRAMES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    input  logic blank,
    output logic frame_tick,
    output logic done
);
    logic [31:0] pre;
    logic [31:0] cnt;
    logic        last;
    always_comb begin
        frame_tick = run && pre == 32'(CLK_DIV - 1);
        last       = cnt == (blank ? 32'(BLANK_FRAMES - 1) : 32'(HOLD_FRAMES - 1));
        done       = frame_tick && last;
    end
    // every state change happens on done, so clearing on done is the state-entry clear
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            pre <= '0;
            cnt <= '0;
        end else if (!run || clr) begin
            pre <= '0;
            cnt <= '0;
        end else begin
            pre <= frame_tick ? '0 : pre + 32'd1;
            cnt <= done ? '0 : frame_tick ? cnt + 32'd1 : cnt;
        end
endmodule

// File: rtl/rgb_led_frame_sched.sv
// rgb_led_frame_sched: shows LFSR patterns and granted override patterns with blanking between them.
// Optional LED_PWM_EN adds a bright[3:0] input and a 16-step PWM mask on led_out.
module rgb_led_frame_sched
    import rgb_led_pkg::*;
#(
    parameter int CLK_DIV      = 50000000,
    parameter int HOLD_FRAMES  = 4,
    parameter int BLANK_FRAMES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [12:0]      rnd_in,
    input  logic             ovr_req,
    input  logic [LED_W-1:0] ovr_pat,
`ifdef LED_PWM_EN
    input  logic [3:0]       bright,
`endif
    output logic             ovr_gnt,
    output logic [LED_W-1:0] led_out,
    output logic             frame_tick,
    output logic             busy
);
    state_t           state;
    logic [LED_W-1:0] pat;
    logic             done;
    logic             unused_rnd;
    assign unused_rnd = rnd_in[12];
    assign busy       = state != IDLE;
    // grant only on the blank exit tick so a running pattern is never cut short
    assign ovr_gnt    = en && state == BLANK && done && ovr_req;

    led_frame_timer #(
        .CLK_DIV     (CLK_DIV),
        .HOLD_FRAMES (HOLD_FRAMES),
        .BLANK_FRAMES(BLANK_FRAMES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .run       (busy),
        .clr       (!en),
        .blank     (state == BLANK),
        .frame_tick(frame_tick),
        .done      (done)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            pat   <= '0;
        end else if (!en) begin
            state <= IDLE;
            pat   <= '0;
        end else if (state == IDLE || (state == BLANK && done && !ovr_req)) begin
            state <= SHOW_RND;
            pat   <= rnd_in[LED_W-1:0];
        end else if (ovr_gnt) begin
            state <= SHOW_OVR;
            pat   <= ovr_pat;
        end else if (done) begin
            state <= BLANK;
            pat   <= '0;
        end

`ifdef LED_PWM_EN
    logic [3:0] pwm_cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) pwm_cnt <= '0;
        else pwm_cnt <= pwm_cnt + 4'd1;
    assign led_out = pat & {LED_W{pwm_cnt < bright}};
`else
    assign led_out = pat;
`endif
endmodule
